// File: rtl/adder_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_pkg
// Description : Shared constants and types for the adder-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_share_pkg;

   localparam int ADD_W = 16;

   typedef enum logic [0:0] {
      LK_UNLOCKED = 1'b0,
      LK_LOCKED   = 1'b1
   } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/adder16.sv
`default_nettype none
// ============================================================================
// Module      : adder16
// Description : 16-bit ripple-carry adder (datapath building block).
// Revision    : 1.0 - initial release
// ============================================================================
module adder16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_sum,
   output logic        o_cout
);

   logic [16:0] w_c;

   // Bit-serial carry chain, LSB first.
   always_comb begin
      w_c   = '0;
      o_sum = '0;
      for (int i = 0; i < 16; i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout = w_c[16];

endmodule
`default_nettype wire

// File: rtl/adder_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker. Scans upward from
//               i_ptr+1 (wrapping) and grants the first eligible request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   input  logic [NUM_REQ-1:0] i_mask,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_idx
);

   logic [NUM_REQ-1:0] w_elig;
   logic [ID_W-1:0]    w_j;
   int                 w_pos;

   assign w_elig = i_req & i_mask;

   // Walk from the farthest slot to the nearest so the nearest eligible
   // request is the last one written and therefore wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      w_pos = 0;
      w_j   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
         w_j = ID_W'(w_pos);
         if (w_elig[w_j]) begin
            o_gnt      = '0;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arb
// Description : Round-robin arbiter time-sharing one adder16 among NUM_REQ
//               requesters, with a single-entry registered result.
//               Optional grant locking: define ADDER_SHARE_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arb
   import adder_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [ADD_W*NUM_REQ-1:0] req_a,
   input  logic [ADD_W*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_lock,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ADD_W-1:0]         rsp_sum,
   output logic [ID_W-1:0]          rsp_id
);

   logic               r_rsp_valid;
   logic [ADD_W-1:0]   r_rsp_sum;
   logic [ID_W-1:0]    r_rsp_id;
   logic [ID_W-1:0]    r_ptr;
   logic               w_can_accept;
   logic               w_xfer;
   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_idx;
   logic [ADD_W-1:0]   w_op_a;
   logic [ADD_W-1:0]   w_op_b;
   logic [ADD_W-1:0]   w_sum;
   logic               w_unused_cout;

   assign w_can_accept = !r_rsp_valid | rsp_ready;
   assign req_ready    = w_can_accept ? w_gnt : '0;
   assign w_xfer       = w_can_accept & (|w_gnt);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req  (req_valid),
      .i_ptr  (r_ptr),
      .i_mask (w_mask),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx)
   );

   assign w_op_a = req_a[int'(w_idx)*ADD_W +: ADD_W];
   assign w_op_b = req_b[int'(w_idx)*ADD_W +: ADD_W];

   adder16 u_add (
      .i_a    (w_op_a),
      .i_b    (w_op_b),
      .o_sum  (w_sum),
      .o_cout (w_unused_cout)
   );

`ifdef ADDER_SHARE_ARB_LOCK_EN
   lock_state_t      r_lk_state;
   lock_state_t      w_lk_state_nxt;
   logic [ID_W-1:0]  r_lk_owner;
   logic [ID_W-1:0]  w_lk_owner_nxt;
   logic             w_owner_valid;

   assign w_owner_valid = req_valid[r_lk_owner];

   // A lock whose owner has gone idle is released in the same cycle, so the
   // mask only narrows to the owner while the owner is still requesting.
   always_comb begin
      w_mask = '1;
      if (r_lk_state == LK_LOCKED && w_owner_valid) begin
         w_mask             = '0;
         w_mask[r_lk_owner] = 1'b1;
      end
   end

   // Lock next-state: enter on a locking transfer, leave on an unlocking
   // transfer from the owner or when the owner drops its request.
   always_comb begin
      w_lk_state_nxt = r_lk_state;
      w_lk_owner_nxt = r_lk_owner;
      case (r_lk_state)
         LK_UNLOCKED: begin
            if (w_xfer && req_lock[w_idx]) begin
               w_lk_state_nxt = LK_LOCKED;
               w_lk_owner_nxt = w_idx;
            end
         end
         LK_LOCKED: begin
            if (!w_owner_valid) begin
               w_lk_state_nxt = LK_UNLOCKED;
            end else if (w_xfer && !req_lock[r_lk_owner]) begin
               w_lk_state_nxt = LK_UNLOCKED;
            end
         end
         default: w_lk_state_nxt = LK_UNLOCKED;
      endcase
   end

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk_state <= LK_UNLOCKED;
         r_lk_owner <= '0;
      end else begin
         r_lk_state <= w_lk_state_nxt;
         r_lk_owner <= w_lk_owner_nxt;
      end
   end
`else
   logic w_unused_lock;

   assign w_mask        = '1;
   assign w_unused_lock = ^req_lock;
`endif

   // Result register and round-robin pointer; a transfer always wins over
   // a drain so back-to-back results keep rsp_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_id    <= '0;
         r_ptr       <= ID_W'(NUM_REQ - 1);
      end else if (w_xfer) begin
         r_rsp_valid <= 1'b1;
         r_rsp_sum   <= w_sum;
         r_rsp_id    <= w_idx;
         r_ptr       <= w_idx;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arb
// Description : Self-checking bench for adder_share_arb (NUM_REQ=4).
//               Lock scenarios run when ADDER_SHARE_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arb;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [16*N-1:0]  req_a;
   logic [16*N-1:0]  req_b;
   logic [N-1:0]     req_lock;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [15:0]      rsp_sum;
   logic [IDW-1:0]   rsp_id;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_ptr;
   bit m_valid;
   int m_sum;
   int m_id;
   bit m_locked;
   int m_owner;

   always #5 clk = ~clk;

   adder_share_arb #(.NUM_REQ(N), .ID_W(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_lock  (req_lock),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = N - 1;
      m_valid  = 0;
      m_sum    = 0;
      m_id     = 0;
      m_locked = 0;
      m_owner  = 0;
   endtask

   task automatic set_req(input int i, input bit v, input logic [15:0] a,
                          input logic [15:0] b, input bit lk);
      req_valid[i]        = v;
      req_a[16*i +: 16]   = a;
      req_b[16*i +: 16]   = b;
      req_lock[i]         = lk;
   endtask

   // Who should win, given the spec rules, for the current inputs.
   function automatic int pick(input logic [N-1:0] rv, input bit rr);
      bit narrow;
      if (m_valid && !rr) return -1;
      narrow = 0;
`ifdef ADDER_SHARE_ARB_LOCK_EN
      narrow = m_locked && rv[m_owner];
`endif
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (rv[j] && (!narrow || j == m_owner)) return j;
      end
      return -1;
   endfunction

   // One clock: check the grant mid-cycle, advance the model, check outputs.
   task automatic step(input string tag);
      int g;
      logic [N-1:0] rv, lk;
      logic [15:0]  a, b;
      bit rr;
      @(negedge clk);
      rv = req_valid;
      lk = req_lock;
      rr = rsp_ready;
      g  = pick(rv, rr);
      check($sformatf("%s.req_ready", tag), 32'(req_ready), (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
         a = req_a[16*g +: 16];
         b = req_b[16*g +: 16];
      end else begin
         a = '0;
         b = '0;
      end
      @(posedge clk);
      #1;
`ifdef ADDER_SHARE_ARB_LOCK_EN
      if (m_locked) begin
         if (!rv[m_owner]) m_locked = 0;
         else if (g == m_owner && !lk[m_owner]) m_locked = 0;
      end else if (g >= 0 && lk[g]) begin
         m_locked = 1;
         m_owner  = g;
      end
`endif
      if (g >= 0) begin
         m_sum   = (int'(a) + int'(b)) % 65536;
         m_id    = g;
         m_valid = 1;
         m_ptr   = g;
      end else if (rr) begin
         m_valid = 0;
      end
      check($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(m_valid));
      check($sformatf("%s.rsp_sum", tag),   32'(rsp_sum),   32'(m_sum));
      check($sformatf("%s.rsp_id", tag),    32'(rsp_id),    32'(m_id));
   endtask

   task automatic all_valid(input bit lk1);
      for (int i = 0; i < N; i++)
         set_req(i, 1'b1, 16'($urandom), 16'($urandom), (i == 1) ? lk1 : 1'b0);
   endtask

   initial begin
      int exp_seq[7];

      // ---- Reset at power-up
      rst_n     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("reset.rsp_valid", 32'(rsp_valid), 0);
      check("reset.rsp_sum",   32'(rsp_sum),   0);
      check("reset.rsp_id",    32'(rsp_id),    0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- All valid after reset: requester 0 first
      all_valid(1'b0);
      step("first");
      check("first.id0", 32'(rsp_id), 0);

      // ---- Single request from req 2 with carry-out edge cases
      req_valid = '0;
      set_req(2, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
      step("single_a");
      check("single_a.sum8000", 32'(rsp_sum), 32'h8000);
      check("single_a.id2",     32'(rsp_id),  2);
      set_req(2, 1'b1, 16'hFFFF, 16'h0002, 1'b0);
      step("single_b");
      check("single_b.sum0001", 32'(rsp_sum), 32'h0001);

      // ---- Round-robin with everyone valid
      for (int c = 0; c < 8; c++) begin
         all_valid(1'b0);
         step($sformatf("rr%0d", c));
         check($sformatf("rr%0d.seq", c), 32'(rsp_id), 32'((3 + c) % N));
      end

      // ---- Backpressure while FULL, then release
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) step($sformatf("stall%0d", c));
      rsp_ready = 1'b1;
      step("unstall");

      // ---- Randomized traffic
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         rsp_ready = 1'($urandom_range(0, 3) != 0);
         step($sformatf("rand%0d", c));
      end

      // ---- Asynchronous reset mid-stream with a result held
      req_valid = '0;
      req_lock  = '0;
      rsp_ready = 1'b1;
      set_req(3, 1'b1, 16'h1234, 16'h1111, 1'b0);
      step("pre_rst");
      check("pre_rst.full", 32'(rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      model_reset();
      check("async_rst.rsp_valid", 32'(rsp_valid), 0);
      check("async_rst.rsp_sum",   32'(rsp_sum),   0);
      check("async_rst.rsp_id",    32'(rsp_id),    0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      all_valid(1'b0);
      step("post_rst");
      check("post_rst.id0", 32'(rsp_id), 0);

`ifdef ADDER_SHARE_ARB_LOCK_EN
      // ---- Lock held by req 1 for four transfers (ptr is 0 here)
      exp_seq = '{1, 1, 1, 1, 2, 3, 0};
      all_valid(1'b1);
      for (int c = 0; c < 7; c++) begin
         if (c == 3) req_lock[1] = 1'b0;
         if (c == 4) req_valid[1] = 1'b0;
         step($sformatf("lock%0d", c));
         check($sformatf("lock%0d.seq", c), 32'(rsp_id), 32'(exp_seq[c]));
      end

      // ---- Owner req 3 drops its request while locked
      req_valid = '0;
      set_req(3, 1'b1, 16'h0010, 16'h0020, 1'b1);
      step("own3");
      check("own3.id", 32'(rsp_id), 3);
      all_valid(1'b0);
      req_valid[3] = 1'b0;
      step("drop0");
      check("drop0.id", 32'(rsp_id), 0);
      step("drop1");
      check("drop1.id", 32'(rsp_id), 1);
`else
      exp_seq = '{0, 0, 0, 0, 0, 0, 0};
      // Without the lock feature req_lock must be ignored.
      all_valid(1'b1);
      for (int c = 0; c < 4; c++) begin
         step($sformatf("nolock%0d", c));
         check($sformatf("nolock%0d.seq", c), 32'(rsp_id), 32'((1 + c + exp_seq[c]) % N));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
